// File: rtl/restador_pkg.sv
// restador_pkg: width defaults shared between the adder pipeline and the
// subtractor pipeline (restador_pipe) that recovers an adder operand.
package restador_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int IDX_W_DEF  = 4;
    localparam int HALF_W     = DATA_W_DEF / 2;

endpackage : restador_pkg

// File: rtl/restador_etapa.sv
// restador_etapa: half-width subtractor with borrow-in and borrow-out.
// diff = a - b - bin (mod 2^W); bout is set when the true result is negative.
module restador_etapa
    import restador_pkg::*;
#(
    parameter int W = HALF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] full;

    // One guard bit above the operands captures the borrow out.
    assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign diff = full[W-1:0];
    assign bout = full[W];

endmodule : restador_etapa

// File: rtl/restador_pipe.sv
// restador_pipe: two-stage valid/ready subtractor, dataB_dd = sum_in - dataA.
// Stage 1 subtracts the low halves, stage 2 the high halves with the stage-1
// borrow. Optional feature: define RESTADOR_BORROW_EN to expose the final
// borrow on borrow_dd; otherwise borrow_dd is tied low and not registered.
module restador_pipe
    import restador_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] sum_in,
    input  logic [DATA_W-1:0] dataA,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] dataB_dd,
    output logic [IDX_W-1:0]  idx_dd,
    output logic              borrow_dd
);

    localparam int H = DATA_W / 2;

    // Stage 1 registers
    logic             s1_valid;
    logic [H-1:0]     s1_lo;
    logic             s1_borrow;
    logic [H-1:0]     s1_a_hi;
    logic [H-1:0]     s1_b_hi;
    logic [IDX_W-1:0] s1_idx;

    // Stage 2 registers
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic [IDX_W-1:0]  s2_idx;

    logic          s1_load;
    logic          s2_load;
    logic [H-1:0]  lo_diff;
    logic          lo_borrow;
    logic [H-1:0]  hi_diff;
    logic          hi_borrow;

    // A stage loads when it is empty or the stage downstream of it moves on.
    assign s2_load  = ~s2_valid | ready_out;
    assign s1_load  = ~s1_valid | s2_load;
    assign ready_in = s1_load & ~reset;

    restador_etapa #(.W(H)) u_etapa_lo (
        .a    (sum_in[H-1:0]),
        .b    (dataA[H-1:0]),
        .bin  (1'b0),
        .diff (lo_diff),
        .bout (lo_borrow)
    );

    restador_etapa #(.W(H)) u_etapa_hi (
        .a    (s1_a_hi),
        .b    (s1_b_hi),
        .bin  (s1_borrow),
        .diff (hi_diff),
        .bout (hi_borrow)
    );

    // Stage 1: capture the low-half difference, its borrow and the high halves.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_borrow <= 1'b0;
            s1_a_hi   <= '0;
            s1_b_hi   <= '0;
            s1_idx    <= '0;
        end else if (s1_load) begin
            s1_valid  <= valid_in;
            s1_lo     <= lo_diff;
            s1_borrow <= lo_borrow;
            s1_a_hi   <= sum_in[DATA_W-1:H];
            s1_b_hi   <= dataA[DATA_W-1:H];
            s1_idx    <= idx;
        end
    end

    // Stage 2: assemble the full result from the high-half difference.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_idx   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_data  <= {hi_diff, s1_lo};
            s2_idx   <= s1_idx;
        end
    end

`ifdef RESTADOR_BORROW_EN
    logic s2_borrow;

    // Stage 2 borrow register, loaded and held together with the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_borrow <= 1'b0;
        end else if (s2_load) begin
            s2_borrow <= hi_borrow;
        end
    end

    assign borrow_dd = s2_borrow;
`else
    // Final borrow is not needed downstream in this build.
    logic unused_hi_borrow;
    assign unused_hi_borrow = hi_borrow;
    assign borrow_dd        = 1'b0;
`endif

    assign valid_out = s2_valid;
    assign dataB_dd  = s2_data;
    assign idx_dd    = s2_idx;

endmodule : restador_pipe

// File: tb/tb_restador_pipe.sv
// tb_restador_pipe: directed and random stimulus for restador_pipe, checked
// against a queue-based reference of expected results in acceptance order.
module tb_restador_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic       ready_in;
    logic [3:0] idx;
    logic [3:0] sum_in;
    logic [3:0] dataA;
    logic       valid_out;
    logic       ready_out;
    logic [3:0] dataB_dd;
    logic [3:0] idx_dd;
    logic       borrow_dd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic [3:0] d;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   n_out   = 0;
    int   run     = 0;
    int   max_run = 0;
    logic hold_pend = 1'b0;
    exp_t hold_v;

    always #5 clk = ~clk;

    restador_pipe #(.DATA_W(4), .IDX_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .idx       (idx),
        .sum_in    (sum_in),
        .dataA     (dataA),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .dataB_dd  (dataB_dd),
        .idx_dd    (idx_dd),
        .borrow_dd (borrow_dd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] i, input logic [3:0] s, input logic [3:0] a);
        exp_t e;
        int   diff;
        diff  = int'(s) - int'(a);
        e.idx = i;
        e.d   = 4'((diff < 0) ? diff + 16 : diff);
`ifdef RESTADOR_BORROW_EN
        e.b   = (diff < 0);
`else
        e.b   = 1'b0;
`endif
        return e;
    endfunction

    task automatic drive(input logic v, input logic [3:0] i, input logic [3:0] s,
                         input logic [3:0] a, input logic ro);
        valid_in  = v;
        idx       = i;
        sum_in    = s;
        dataA     = a;
        ready_out = ro;
    endtask

    // One clock: observe handshakes mid-cycle, then advance past the edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            q.delete();
            hold_pend = 1'b0;
            run = 0;
        end else begin
            if (hold_pend && valid_out) begin
                chk("hold_data", dataB_dd, hold_v.d);
                chk("hold_idx", idx_dd, hold_v.idx);
                chk("hold_borrow", borrow_dd, hold_v.b);
            end
            if (valid_out && !ready_out) begin
                hold_pend = 1'b1;
                hold_v.d = dataB_dd;
                hold_v.idx = idx_dd;
                hold_v.b = borrow_dd;
            end else begin
                hold_pend = 1'b0;
            end
            run = valid_out ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (valid_in && ready_in) q.push_back(model(idx, sum_in, dataA));
            if (valid_out && ready_out) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", dataB_dd, e.d);
                    chk("out_idx", idx_dd, e.idx);
                    chk("out_borrow", borrow_dd, e.b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        logic exp_b;
        reset = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        #1;
        step();
        chk("ready_in_in_reset", ready_in, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_dataB", dataB_dd, 4'h0);
        chk("rst_idx", idx_dd, 4'h0);
        chk("rst_borrow", borrow_dd, 1'b0);
        chk("rst_ready_in", ready_in, 1'b1);

        // 9 - 5 = 4, latency 2
        drive(1'b1, 4'h3, 4'h9, 4'h5, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("lat1_valid_out", valid_out, 1'b0);
        step();
        chk("basic_valid", valid_out, 1'b1);
        chk("basic_data", dataB_dd, 4'h4);
        chk("basic_idx", idx_dd, 4'h3);
        chk("basic_borrow", borrow_dd, 1'b0);
        step();

        // 3 - 7 wraps to C with borrow
`ifdef RESTADOR_BORROW_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        drive(1'b1, 4'hA, 4'h3, 4'h7, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        step();
        chk("wrap_valid", valid_out, 1'b1);
        chk("wrap_data", dataB_dd, 4'hC);
        chk("wrap_idx", idx_dd, 4'hA);
        chk("wrap_borrow", borrow_dd, exp_b);
        step();

        // 16 back-to-back transactions
        max_run = 0;
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 4'(i + 2), 4'(i), 1'b1);
            step();
        end
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("b2b_count", n_out - n0, 16);
        chk("b2b_consecutive", max_run, 16);

        // back-pressure with two in flight
        n0 = n_out;
        drive(1'b1, 4'h1, 4'h8, 4'h3, 1'b1);
        step();
        drive(1'b1, 4'h2, 4'h6, 4'h9, 1'b1);
        step();
        drive(1'b1, 4'h3, 4'hF, 4'h1, 1'b0);
        #1;
        chk("bp_ready_in", ready_in, 1'b0);
        chk("bp_valid_out", valid_out, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready_in_hold", ready_in, 1'b0);
        end
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        chk("bp_drained", n_out - n0, 2);
        chk("bp_queue_empty", q.size(), 0);

        // reset with both stages full
        drive(1'b1, 4'h4, 4'h5, 4'h1, 1'b0);
        step();
        drive(1'b1, 4'h5, 4'h6, 4'h2, 1'b0);
        step();
        chk("pre_rst_valid", valid_out, 1'b1);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_pulse_ready_in", ready_in, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("rst2_valid_out", valid_out, 1'b0);
        chk("rst2_dataB", dataB_dd, 4'h0);
        chk("rst2_idx", idx_dd, 4'h0);
        chk("rst2_borrow", borrow_dd, 1'b0);
        drive(1'b1, 4'h7, 4'hE, 4'h1, 1'b1);
        #1;
        chk("post_rst_ready", ready_in, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("post_rst_lat1", valid_out, 1'b0);
        step();
        chk("post_rst_valid", valid_out, 1'b1);
        chk("post_rst_data", dataB_dd, 4'hD);
        chk("post_rst_idx", idx_dd, 4'h7);
        step();

        // random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
            step();
        end
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        chk("final_queue_empty", q.size(), 0);
        chk("final_valid_out", valid_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_restador_pipe
